// File: rtl/sw_reg_bank_wr_pkg.sv
// sw_reg_bank_wr_pkg: shared types and helpers for the sw_reg_bank_wr slave.
//   state_e    response FSM states
//   rsp_e      registered termination encoding (RSP_NONE/RSP_ACK/RSP_ERR)
//   be_width   byte-enable width of a W-bit bus
//   commit_off offset of the commit register behind NUM_REGS data registers
package sw_reg_bank_wr_pkg;
  typedef enum logic {IDLE, RESP} state_e;
  typedef enum logic [1:0] {RSP_NONE, RSP_ACK, RSP_ERR} rsp_e;
  function automatic int be_width(input int w);
    return w / 8;
  endfunction
  function automatic int commit_off(input int n);
    return n;
  endfunction
endpackage

// File: rtl/sw_reg_byte_wr.sv
// sw_reg_byte_wr: one W-bit register with per-byte load enables and reset value.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   be_i          per-byte load enables
//   d_i           load data
//   q_o           register contents
module sw_reg_byte_wr
  import sw_reg_bank_wr_pkg::*;
#(
  parameter int             W         = 32,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [be_width(W)-1:0] be_i,
  input  logic [W-1:0]           d_i,
  output logic [W-1:0]           q_o
);
  localparam int BW = be_width(W);
  logic [W-1:0] data_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) data_q <= RESET_VAL;
    else
      for (int k = 0; k < BW; k++)
        if (be_i[k]) data_q[k*8 +: 8] <= d_i[k*8 +: 8];
  assign q_o = data_q;
endmodule

// File: rtl/sw_reg_bank_wr.sv
// sw_reg_bank_wr: wishbone bank of software-writable registers driving fabric controls.
//   wb_clk_i/wb_rst_i          clock, asynchronous active-high reset
//   wbs_*_i / wbs_*_o          wishbone slave; one registered ack or err per accepted access
//   fabric_data_o              register i at [i*W +: W]
//   fabric_wr_stb_o            one-cycle pulse, with ack, when output slice i is loaded
//   SW_REG_BANK_WR_SHADOW_EN   writes land in shadows, copied to outputs by the commit register
module sw_reg_bank_wr
  import sw_reg_bank_wr_pkg::*;
#(
  parameter int                          BUS_DATA_WIDTH = 32,
  parameter int                          BUS_ADDR_WIDTH = 8,
  parameter int                          NUM_REGS       = 4,
  parameter int                          DEV_BASE_ADDR  = 0,
  parameter int                          DEV_HIGH_ADDR  = DEV_BASE_ADDR + NUM_REGS * 2,
  parameter logic [BUS_DATA_WIDTH-1:0]   RESET_VAL      = '0
) (
  input  logic                                wb_clk_i,
  input  logic                                wb_rst_i,
  input  logic                                wbs_cyc_i,
  input  logic                                wbs_stb_i,
  input  logic                                wbs_we_i,
  input  logic [BUS_DATA_WIDTH/8-1:0]         wbs_sel_i,
  input  logic [BUS_ADDR_WIDTH-1:0]           wbs_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0]           wbs_dat_i,
  output logic [BUS_DATA_WIDTH-1:0]           wbs_dat_o,
  output logic                                wbs_ack_o,
  output logic                                wbs_err_o,
  output logic [NUM_REGS*BUS_DATA_WIDTH-1:0]  fabric_data_o,
  output logic [NUM_REGS-1:0]                 fabric_wr_stb_o
);
  localparam int W  = BUS_DATA_WIDTH;
  localparam int AW = BUS_ADDR_WIDTH;
  localparam int BW = be_width(W);
  localparam int COMMIT = commit_off(NUM_REGS);
  state_e state_q, state_d;
  rsp_e rsp_q, rsp_d;
  logic [W-1:0] dat_q, dat_d, rd;
  logic [NUM_REGS-1:0] stb_q, upd;
  logic [W-1:0] sh [NUM_REGS];
  logic [AW-1:0] off;
  logic in_win, accept, reg_hit, commit_hit, wr;
  assign off = wbs_adr_i - AW'(DEV_BASE_ADDR);
  assign in_win = wbs_adr_i >= AW'(DEV_BASE_ADDR) && wbs_adr_i <= AW'(DEV_HIGH_ADDR);
  assign accept = in_win & wbs_cyc_i & wbs_stb_i & (state_q == IDLE);
  assign reg_hit = {1'b0, off} < (AW+1)'(NUM_REGS);
`ifdef SW_REG_BANK_WR_SHADOW_EN
  assign commit_hit = off == AW'(COMMIT);
`else
  assign commit_hit = 1'b0;
`endif
  assign wr = accept & wbs_we_i & reg_hit;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic hit_i;
    logic [BW-1:0] be;
    assign hit_i = wr & (off == AW'(i));
    assign be = hit_i ? wbs_sel_i : '0;
`ifdef SW_REG_BANK_WR_SHADOW_EN
    logic cmt;
    // Commit bits beyond the bus width can never be set, so those outputs only load via reset.
    assign cmt = accept & wbs_we_i & commit_hit & wbs_sel_i[0] & (i < W) & wbs_dat_i[i % W];
    sw_reg_byte_wr #(.W(W), .RESET_VAL(RESET_VAL)) u_shadow (
      .clk_i(wb_clk_i), .rst_i(wb_rst_i), .be_i(be), .d_i(wbs_dat_i), .q_o(sh[i]));
    sw_reg_byte_wr #(.W(W), .RESET_VAL(RESET_VAL)) u_out (
      .clk_i(wb_clk_i), .rst_i(wb_rst_i), .be_i({BW{cmt}}), .d_i(sh[i]),
      .q_o(fabric_data_o[i*W +: W]));
    assign upd[i] = cmt;
`else
    sw_reg_byte_wr #(.W(W), .RESET_VAL(RESET_VAL)) u_out (
      .clk_i(wb_clk_i), .rst_i(wb_rst_i), .be_i(be), .d_i(wbs_dat_i),
      .q_o(fabric_data_o[i*W +: W]));
    assign sh[i] = fabric_data_o[i*W +: W];
    assign upd[i] = hit_i & |wbs_sel_i;
`endif
  end
  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (off == AW'(i)) rd = sh[i];
  end
  always_comb begin
    state_d = state_q;
    rsp_d = rsp_q;
    dat_d = dat_q;
    if (state_q == RESP) begin
      state_d = IDLE;
      rsp_d = RSP_NONE;
    end else if (accept) begin
      state_d = RESP;
      rsp_d = (reg_hit | commit_hit) ? RSP_ACK : RSP_ERR;
      dat_d = (reg_hit | commit_hit) && !wbs_we_i ? (reg_hit ? rd : '0) : dat_q;
    end
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state_q <= IDLE;
      rsp_q <= RSP_NONE;
      dat_q <= '0;
      stb_q <= '0;
    end else begin
      state_q <= state_d;
      rsp_q <= rsp_d;
      dat_q <= dat_d;
      stb_q <= upd;
    end
  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = rsp_q == RSP_ACK;
  assign wbs_err_o = rsp_q == RSP_ERR;
  assign fabric_wr_stb_o = stb_q;
endmodule

// File: tb/tb_sw_reg_bank_wr.sv
// tb_sw_reg_bank_wr: scoreboard bench for sw_reg_bank_wr with default parameters.
module tb_sw_reg_bank_wr;
  logic clk = 0, rst = 1, cyc = 0, stb = 0, we = 0;
  logic [3:0] sel = 0;
  logic [7:0] adr = 0;
  logic [31:0] din = 0, dout;
  logic ack, err;
  logic [127:0] fab;
  logic [3:0] wstb;
  typedef struct {
    string tag;
    logic ack;
    logic chk_dat;
    logic [31:0] dat;
    logic [3:0] stb;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, n_ack = 0;
  logic prev_ack = 0;
  logic [31:0] sh_m [4], out_m [4], last_dat = 0;

  sw_reg_bank_wr dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(din), .wbs_dat_o(dout), .wbs_ack_o(ack),
    .wbs_err_o(err), .fabric_data_o(fab), .fabric_wr_stb_o(wstb));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ack || err) begin
        if (ack) n_ack++;
        if (q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk({e.tag, "_ack"}, ack, e.ack);
          chk({e.tag, "_err"}, err, !e.ack);
          chk({e.tag, "_stb"}, wstb, e.stb);
          if (e.chk_dat) chk({e.tag, "_dat"}, dout, e.dat);
        end
      end else if (wstb != 0) chk("stray_stb", wstb, 0);
      if (ack && prev_ack) chk("ack_consecutive", 1, 0);
      prev_ack = ack;
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int k = 0; k < 4; k++) if (s[k]) o[k*8 +: 8] = d[k*8 +: 8];
    return o;
  endfunction

  task automatic bus(input logic w, input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; sel = s; din = d;
    @(negedge clk);
    cyc = 0; stb = 0;
    @(negedge clk);
  endtask

  task automatic wr(input string tag, input int o, input logic [3:0] s, input logic [31:0] d);
    logic [3:0] es;
    es = 0;
    if (o < 4) begin
      sh_m[o] = merge(sh_m[o], d, s);
`ifdef SW_REG_BANK_WR_SHADOW_EN
`else
      out_m[o] = sh_m[o];
      if (s != 0) es[o] = 1;
`endif
      q.push_back('{tag, 1, 0, 0, es});
`ifdef SW_REG_BANK_WR_SHADOW_EN
    end else if (o == 4) begin
      if (s[0]) for (int i = 0; i < 4; i++) if (d[i]) begin out_m[i] = sh_m[i]; es[i] = 1; end
      q.push_back('{tag, 1, 0, 0, es});
`endif
    end else if (o <= 8) q.push_back('{tag, 0, 1, last_dat, 0});
    bus(1, 8'(o), s, d);
  endtask

  task automatic rd(input string tag, input int o);
    if (o < 4) begin
      last_dat = sh_m[o];
      q.push_back('{tag, 1, 1, last_dat, 0});
`ifdef SW_REG_BANK_WR_SHADOW_EN
    end else if (o == 4) begin
      last_dat = 0;
      q.push_back('{tag, 1, 1, 0, 0});
`endif
    end else if (o <= 8) q.push_back('{tag, 0, 1, last_dat, 0});
    bus(0, 8'(o), 4'hF, 32'hFFFF_FFFF);
  endtask

  task automatic chk_fab(input string tag);
    chk(tag, fab, {out_m[3], out_m[2], out_m[1], out_m[0]});
  endtask

  initial begin
    int a0;
    for (int i = 0; i < 4; i++) begin sh_m[i] = 0; out_m[i] = 0; end
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_dat", dout, 0);
    chk("rst_fab", fab, 0);
    chk("rst_stb", wstb, 0);
    for (int i = 0; i < 4; i++) rd($sformatf("rd_init%0d", i), i);
    wr("wr_r2_sel5", 2, 4'b0101, 32'hDEAD_BEEF);
    chk("fab_r2", fab[95:64], 32'h00AD_00EF);
    chk_fab("fab_after_r2");
    rd("rd_r2", 2);
    wr("err_off5", 5, 4'hF, 32'h1234_5678);
    rd("err_off8", 8);
    chk_fab("fab_after_err");
    wr("out_of_window", 9, 4'hF, 32'hCAFE_F00D);
    chk("oow_noresp", q.size(), 0);
    wr("sel0", 1, 4'b0000, 32'hFFFF_FFFF);
    wr("wr_r0", 0, 4'hF, 32'hA5A5_5A5A);
    wr("wr_r3_hi", 3, 4'b1100, 32'h1357_9BDF);
    wr("wr_r1_b1", 1, 4'b0010, 32'h0000_7700);
    for (int i = 0; i < 4; i++) rd($sformatf("rd_back%0d", i), i);
    chk_fab("fab_mix");
`ifdef SW_REG_BANK_WR_SHADOW_EN
    wr("sh_wr0", 0, 4'hF, 32'h11);
    wr("sh_wr1", 1, 4'hF, 32'h22);
    chk_fab("sh_fab_unchanged");
    rd("sh_rd_commit", 4);
    wr("sh_commit", 4, 4'b0001, 32'h3);
    chk("sh_fab0", fab[31:0], 32'h11);
    chk("sh_fab1", fab[63:32], 32'h22);
    chk_fab("sh_fab_commit");
`else
    wr("err_commit_off", 4, 4'b0001, 32'h3);
    chk_fab("fab_after_off4");
`endif
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 8'd2; sel = 4'hF; din = 32'h0BAD_0BAD; rst = 1;
    @(negedge clk);
    rst = 0; cyc = 0; stb = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin sh_m[i] = 0; out_m[i] = 0; end
    last_dat = 0;
    chk("rst_mid_dat", dout, 0);
    chk_fab("rst_mid_fab");
    rd("rd_after_rst", 2);
    wr("wr_r0_pre_b2b", 0, 4'hF, 32'h0F0F_1234);
    a0 = n_ack;
    for (int i = 0; i < 3; i++) q.push_back('{"b2b", 1, 1, 32'h0F0F_1234, 0});
    last_dat = 32'h0F0F_1234;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 0; sel = 4'hF;
    repeat (6) @(negedge clk);
    cyc = 0; stb = 0;
    repeat (2) @(negedge clk);
    chk("b2b_acks", n_ack - a0, 3);
    repeat (3) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
